// File: rtl/stream_demux_pkt_if.sv
// Stream bus for stream_demux_pkt: one input stream and NCH output channels sharing one data bus.
// master drives the input stream and consumes the outputs; slave is the demultiplexer.
interface stream_demux_pkt_if #(
    parameter int DW  = 8,
    parameter int NCH = 4
);
    localparam int SW = $clog2(NCH);

    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [SW-1:0]  in_sel;
    logic           in_last;
    logic [NCH-1:0] out_valid;
    logic [NCH-1:0] out_ready;
    logic [DW-1:0]  out_data;
    logic           out_last;

    modport master (
        output in_valid, in_data, in_sel, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/stream_demux_pkt.sv
// 1-to-NCH packet-locked stream demultiplexer with a single registered holding stage.
// Optional dropped-packet counter port drop_cnt enabled by STREAM_DEMUX_DROP_CNT_EN.
module stream_demux_pkt #(
    parameter int DW  = 8,
    parameter int NCH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    stream_demux_pkt_if.slave bus,
    output logic             err_drop
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);
    // state | meaning
    // IDLE  | waiting for the first beat of a packet; in_sel is sampled here
    // FWD   | mid-packet, beats routed to cur_ch
    // DROP  | mid-packet with an out-of-range select, beats consumed and discarded
    localparam int SW    = $clog2(NCH);
    localparam int SEL1W = SW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          hold_v;
    logic          hold_last;
    logic [SW-1:0] hold_ch;
    logic [DW-1:0] hold_data;
    logic [SW-1:0] cur_ch;
    logic [SW-1:0] load_ch;
    logic          sel_bad;
    logic          drain;
    logic          accept;
    logic          load;
    logic          drop_first;

    // Only reachable when NCH is not a power of two.
    assign sel_bad    = ({1'b0, bus.in_sel} >= SEL1W'(NCH));
    assign drain      = hold_v && bus.out_ready[hold_ch];
    assign accept     = bus.in_valid && bus.in_ready;
    assign load       = accept && ((state == IDLE && !sel_bad) || state == FWD);
    assign drop_first = accept && state == IDLE && sel_bad;
    assign load_ch    = (state == FWD) ? cur_ch : bus.in_sel;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                IDLE:      if (!bus.in_last) state_nxt = sel_bad ? DROP : FWD;
                FWD, DROP: if (bus.in_last) state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // Discarded beats never touch the holding register, so they need not wait for it.
    always_comb begin
        bus.out_valid = '0;
        if (state == DROP || (state == IDLE && sel_bad)) begin
            bus.in_ready = 1'b1;
        end else begin
            bus.in_ready = !hold_v || drain;
        end
        for (int i = 0; i < NCH; i++) begin
            bus.out_valid[i] = hold_v && (hold_ch == SW'(i));
        end
    end

    assign bus.out_data = hold_data;
    assign bus.out_last = hold_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_v    <= 1'b0;
            hold_ch   <= '0;
            hold_data <= '0;
            hold_last <= 1'b0;
            cur_ch    <= '0;
            err_drop  <= 1'b0;
        end else begin
            err_drop <= drop_first;
            if (load) begin
                hold_v    <= 1'b1;
                hold_ch   <= load_ch;
                hold_data <= bus.in_data;
                hold_last <= bus.in_last;
            end else if (drain) begin
                hold_v <= 1'b0;
            end
            if (load && state == IDLE) begin
                cur_ch <= bus.in_sel;
            end
        end
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= 16'h0000;
        end else if (drop_first && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'h0001;
        end
    end
`endif
endmodule

// File: tb/tb_stream_demux_pkt.sv
// Bench for stream_demux_pkt: NCH=4 instance (k=0) and NCH=3 instance (k=1) checked against a packet-level model.
module tb_stream_demux_pkt;
    logic clk;
    logic rstn;
    logic err4;
    logic err3;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0] cnt4;
    logic [15:0] cnt3;
`endif

    stream_demux_pkt_if #(.DW(8), .NCH(4)) b4 ();
    stream_demux_pkt_if #(.DW(8), .NCH(3)) b3 ();

    stream_demux_pkt #(.DW(8), .NCH(4)) dut4 (
        .clk(clk), .rstn(rstn), .bus(b4.slave), .err_drop(err4)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        , .drop_cnt(cnt4)
`endif
    );

    stream_demux_pkt #(.DW(8), .NCH(3)) dut3 (
        .clk(clk), .rstn(rstn), .bus(b3.slave), .err_drop(err3)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        , .drop_cnt(cnt3)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet-level model: per instance, whether a packet is open, where it goes (-1 = discarded),
    // and the single beat waiting at the outputs.
    int       nch[2]      = '{4, 3};
    bit       m_in_pkt[2] = '{0, 0};
    int       m_ch[2]     = '{0, 0};
    bit       m_hv[2]     = '{0, 0};
    int       m_hch[2]    = '{0, 0};
    int       m_hd[2]     = '{0, 0};
    bit       m_hl[2]     = '{0, 0};
    bit       m_err[2]    = '{0, 0};
    int       m_cnt[2]    = '{0, 0};

    task automatic get_io(input int k, output logic v, output int sel, output logic [7:0] d,
                          output logic l, output logic [3:0] ordy);
        if (k == 0) begin
            v = b4.in_valid; sel = int'(b4.in_sel); d = b4.in_data; l = b4.in_last;
            ordy = b4.out_ready;
        end else begin
            v = b3.in_valid; sel = int'(b3.in_sel); d = b3.in_data; l = b3.in_last;
            ordy = {1'b0, b3.out_ready};
        end
    endtask

    task automatic get_out(input int k, output logic rdy, output logic [3:0] ov, output logic [7:0] od,
                           output logic ol, output logic err, output logic [15:0] cnt);
        cnt = 16'h0;
        if (k == 0) begin
            rdy = b4.in_ready; ov = b4.out_valid; od = b4.out_data; ol = b4.out_last; err = err4;
`ifdef STREAM_DEMUX_DROP_CNT_EN
            cnt = cnt4;
`endif
        end else begin
            rdy = b3.in_ready; ov = {1'b0, b3.out_valid}; od = b3.out_data; ol = b3.out_last; err = err3;
`ifdef STREAM_DEMUX_DROP_CNT_EN
            cnt = cnt3;
`endif
        end
    endtask

    function automatic logic exp_ready(input int k, input int sel, input logic [3:0] ordy);
        if (m_in_pkt[k] && m_ch[k] < 0) return 1'b1;
        if (!m_in_pkt[k] && sel >= nch[k]) return 1'b1;
        return !m_hv[k] || ordy[m_hch[k]];
    endfunction

    always @(posedge clk or negedge rstn) begin
        for (int k = 0; k < 2; k++) begin
            logic v, l, acc, drn;
            logic [7:0] d;
            logic [3:0] ordy;
            int sel, ch;
            if (!rstn) begin
                m_in_pkt[k] = 0; m_ch[k] = 0; m_hv[k] = 0; m_hch[k] = 0;
                m_hd[k] = 0; m_hl[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
            end else begin
                get_io(k, v, sel, d, l, ordy);
                acc = v && exp_ready(k, sel, ordy);
                drn = m_hv[k] && ordy[m_hch[k]];
                m_err[k] = 0;
                if (drn) m_hv[k] = 0;
                if (acc) begin
                    ch = m_in_pkt[k] ? m_ch[k] : ((sel >= nch[k]) ? -1 : sel);
                    if (!m_in_pkt[k] && ch < 0) begin
                        m_err[k] = 1;
                        if (m_cnt[k] < 65535) m_cnt[k]++;
                    end
                    if (ch >= 0) begin
                        m_hv[k] = 1; m_hch[k] = ch; m_hd[k] = int'(d); m_hl[k] = l;
                    end
                    m_in_pkt[k] = !l;
                    m_ch[k] = ch;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic v, l, rdy, ol, err;
            logic [7:0] d, od;
            logic [3:0] ordy, ov, exp_ov;
            logic [15:0] cnt;
            int sel;
            get_io(k, v, sel, d, l, ordy);
            get_out(k, rdy, ov, od, ol, err, cnt);
            exp_ov = m_hv[k] ? 4'(1 << m_hch[k]) : 4'b0000;
            chk($sformatf("m%0d_in_ready", k), 32'(rdy), 32'(exp_ready(k, sel, ordy)));
            chk($sformatf("m%0d_out_valid", k), 32'(ov), 32'(exp_ov));
            if (m_hv[k]) begin
                chk($sformatf("m%0d_out_data", k), 32'(od), 32'(m_hd[k]));
                chk($sformatf("m%0d_out_last", k), 32'(ol), 32'(m_hl[k]));
            end
            chk($sformatf("m%0d_err_drop", k), 32'(err), 32'(m_err[k]));
`ifdef STREAM_DEMUX_DROP_CNT_EN
            chk($sformatf("m%0d_drop_cnt", k), 32'(cnt), 32'(m_cnt[k]));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int k, input logic v, input int sel, input logic [7:0] d, input logic l);
        if (k == 0) begin
            b4.in_valid = v; b4.in_sel = 2'(sel); b4.in_data = d; b4.in_last = l;
        end else begin
            b3.in_valid = v; b3.in_sel = 2'(sel); b3.in_data = d; b3.in_last = l;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sb_sel[4]  = '{0, 2, 3, 1};
        logic [7:0] sb_dat[4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
        logic [3:0] sb_ov[4]  = '{4'b0001, 4'b0100, 4'b1000, 4'b0010};
        int pl_sel[3]  = '{2, 0, 1};
        logic [7:0] pl_dat[3] = '{8'h11, 8'h22, 8'h33};

        rstn = 1'b0;
        set_in(0, 0, 0, 8'h00, 0);
        set_in(1, 0, 0, 8'h00, 0);
        b4.out_ready = 4'b1111;
        b3.out_ready = 3'b111;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        chk("rst_ov4", 32'(b4.out_valid), 32'h0);
        chk("rst_od4", 32'(b4.out_data), 32'h0);
        chk("rst_err4", 32'(err4), 32'h0);
        chk("rst_ov3", 32'(b3.out_valid), 32'h0);
        tick();

        // single-beat packets on consecutive cycles
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, sb_sel[i], sb_dat[i], 1);
            #1 chk("sb_rdy", 32'(b4.in_ready), 32'h1);
            tick();
            chk("sb_ov", 32'(b4.out_valid), 32'(sb_ov[i]));
            chk("sb_od", 32'(b4.out_data), 32'(sb_dat[i]));
        end
        set_in(0, 0, 0, 8'h00, 0);
        tick();
        chk("sb_idle_ov", 32'(b4.out_valid), 32'h0);

        // packet lock: select changes mid-packet are ignored
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, pl_sel[i], pl_dat[i], (i == 2));
            tick();
            chk("pl_ov", 32'(b4.out_valid), 32'b0100);
            chk("pl_od", 32'(b4.out_data), 32'(pl_dat[i]));
            chk("pl_last", 32'(b4.out_last), 32'((i == 2) ? 1 : 0));
        end
        set_in(0, 0, 0, 8'h00, 0);
        tick();

        // backpressure on channel 1; channel 0 ready is irrelevant
        b4.out_ready = 4'b1101;
        set_in(0, 1, 1, 8'h77, 1);
        tick();
        chk("bp_ov0", 32'(b4.out_valid), 32'b0010);
        set_in(0, 1, 1, 8'h78, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rdy", 32'(b4.in_ready), 32'h0);
            chk("bp_ov", 32'(b4.out_valid), 32'b0010);
            chk("bp_od", 32'(b4.out_data), 32'h77);
            tick();
        end
        b4.out_ready = 4'b1111;
        #1 chk("bp_rdy_up", 32'(b4.in_ready), 32'h1);
        tick();
        chk("bp_next_ov", 32'(b4.out_valid), 32'b0010);
        chk("bp_next_od", 32'(b4.out_data), 32'h78);
        set_in(0, 0, 0, 8'h00, 0);
        tick();
        chk("bp_idle_ov", 32'(b4.out_valid), 32'h0);

        // channel switch while the previous last beat is stalled
        b4.out_ready = 4'b1110;
        set_in(0, 1, 0, 8'h40, 1);
        tick();
        chk("cs_ov0", 32'(b4.out_valid), 32'b0001);
        set_in(0, 1, 3, 8'h41, 1);
        #1 chk("cs_rdy0", 32'(b4.in_ready), 32'h0);
        tick();
        chk("cs_ov_hold", 32'(b4.out_valid), 32'b0001);
        chk("cs_od_hold", 32'(b4.out_data), 32'h40);
        chk("cs_rdy1", 32'(b4.in_ready), 32'h0);
        b4.out_ready = 4'b1111;
        #1 chk("cs_rdy2", 32'(b4.in_ready), 32'h1);
        tick();
        chk("cs_ov3", 32'(b4.out_valid), 32'b1000);
        chk("cs_od3", 32'(b4.out_data), 32'h41);
        set_in(0, 0, 0, 8'h00, 0);
        tick();

        // NCH=3: out-of-range select is consumed and reported once
        set_in(1, 1, 3, 8'hD0, 0);
        #1 chk("dr_rdy0", 32'(b3.in_ready), 32'h1);
        tick();
        chk("dr_ov0", 32'(b3.out_valid), 32'h0);
        chk("dr_err0", 32'(err3), 32'h1);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        chk("dr_cnt1", 32'(cnt3), 32'h1);
`endif
        set_in(1, 1, 0, 8'hD1, 1);
        #1 chk("dr_rdy1", 32'(b3.in_ready), 32'h1);
        tick();
        chk("dr_ov1", 32'(b3.out_valid), 32'h0);
        chk("dr_err1", 32'(err3), 32'h0);
        set_in(1, 1, 1, 8'h55, 1);
        tick();
        chk("dr_ov2", 32'(b3.out_valid), 32'b010);
        chk("dr_od2", 32'(b3.out_data), 32'h55);
        chk("dr_err2", 32'(err3), 32'h0);
        set_in(1, 1, 3, 8'h66, 1);
        tick();
        chk("dr1_err", 32'(err3), 32'h1);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        chk("dr1_cnt", 32'(cnt3), 32'h2);
`endif
        set_in(1, 1, 2, 8'h67, 1);
        tick();
        chk("dr1_ov", 32'(b3.out_valid), 32'b100);
        chk("dr1_od", 32'(b3.out_data), 32'h67);
        chk("dr1_err_gone", 32'(err3), 32'h0);
        set_in(1, 0, 0, 8'h00, 0);
        tick();

        // asynchronous reset mid-packet
        b4.out_ready = 4'b1011;
        set_in(0, 1, 2, 8'h99, 0);
        tick();
        chk("ar_ov_pre", 32'(b4.out_valid), 32'b0100);
        #1 rstn = 1'b0;
        #1;
        chk("ar_ov", 32'(b4.out_valid), 32'h0);
        chk("ar_od", 32'(b4.out_data), 32'h0);
        chk("ar_last", 32'(b4.out_last), 32'h0);
        chk("ar_err", 32'(err4), 32'h0);
        set_in(0, 0, 0, 8'h00, 0);
        tick();
        tick();
        rstn = 1'b1;
        b4.out_ready = 4'b1111;
        set_in(0, 1, 0, 8'h5A, 1);
        tick();
        chk("ar_post_ov", 32'(b4.out_valid), 32'b0001);
        chk("ar_post_od", 32'(b4.out_data), 32'h5A);
        set_in(0, 0, 0, 8'h00, 0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/stream_demux_pkt.md
Name: stream_demux_pkt

Overview:
- Parametrised 1-to-NCH stream demultiplexer with a valid/ready handshake, a registered output stage and packet-locked routing.
- Channel select is sampled on the first beat of a packet and held until the beat carrying in_last is accepted.
- Packets with an out-of-range select are consumed and discarded.
- Used wherever one producer fans out to several consumers (e.g. command router in front of per-lane engines).

Parameters:
- DW, 8: data width in bits.
- NCH, 4: number of output channels, range 2..16.
- SW, derived localparam = $clog2(NCH): select width; not overridable.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rstn  in  1  reset, asynchronous and active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  DW  input payload
- in_sel  in  SW  target channel; sampled only on the first beat of a packet
- in_last  in  1  marks the final beat of a packet
- out_valid  out  NCH  per-channel valid; at most one bit set
- out_ready  in  NCH  per-channel ready
- out_data  out  DW  payload, shared by all channels
- out_last  out  1  last flag of the held beat
- err_drop  out  1  one-cycle pulse when a dropped packet's first beat is accepted

Behaviour:
- Reset (rstn low, asynchronous):
  - out_valid=0, out_data=0, out_last=0, err_drop=0.
  - State=IDLE; internal cur_ch=0.
  - Any packet in flight is abandoned and the holding register is discarded.
- Holding register: one entry (hold_v, hold_ch, hold_data, hold_last).
  - out_valid[i] = hold_v && hold_ch==i.
  - out_data and out_last reflect hold_data and hold_last.
- Output handshake: the entry drains when hold_v && out_ready[hold_ch].
  - Ready bits of non-selected channels are ignored.
- While hold_v && !out_ready[hold_ch], out_valid, out_data and out_last stay stable.
- in_ready:
  - In DROP, or on an IDLE first beat whose in_sel >= NCH: in_ready=1 regardless of the holding register.
  - Otherwise: in_ready = !hold_v || out_ready[hold_ch].
  - This gives full throughput: 1 beat/cycle with a simultaneous drain and load.
- Latency: an accepted beat appears on out_* in the next cycle.
- FSM states: IDLE, FWD, DROP.
  - IDLE, beat accepted, in_sel < NCH:
    - Load the holding register with ch=in_sel.
    - cur_ch <= in_sel.
    - Go to FWD, unless in_last=1 (single-beat packet), in which case stay in IDLE.
  - IDLE, beat accepted, in_sel >= NCH (only possible when NCH is not a power of 2):
    - Discard the beat and pulse err_drop.
    - Go to DROP, unless in_last=1, in which case stay in IDLE.
  - FWD, beat accepted:
    - Load the holding register with ch=cur_ch; in_sel is ignored.
    - Return to IDLE if in_last=1.
  - DROP, beat accepted:
    - Discard the beat; no err_drop pulse.
    - Return to IDLE if in_last=1.
- Simultaneous drain and load in the same cycle: the holding register takes the new beat and hold_v stays 1.
- Back-to-back packets: a new first beat may be accepted in the cycle after the previous last beat. The new select may target a different channel while the old beat is still held; the old beat must drain first (in_ready=0 until it does).
- in_valid low mid-packet: state and cur_ch are held indefinitely.
- err_drop is registered and asserted for exactly one cycle per dropped packet.

Optional Feature:
- Macro: STREAM_DEMUX_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt (16 bits): count of dropped packets.
  - Increments in the same cycle as the err_drop pulse.
  - Saturates at 16'hFFFF; resets to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: drive rstn=0 asynchronously mid-packet while out_valid=0100 -> all outputs go to 0 immediately with no clock edge. After release, a beat with sel=0 is routed to channel 0.
- Single-beat routing, NCH=4, all out_ready=1: beats (sel, data) = (0,A5), (2,3C), (3,FF), (1,01), each with last=1, on consecutive cycles -> out_valid = 0001, 0100, 1000, 0010 one cycle later with matching data; in_ready held at 1.
- Packet lock: 3-beat packet, first sel=2; in_sel toggles to 0 and 1 on beats 2 and 3 -> all three beats appear on channel 2 (out_valid=0100), out_last=1 on the third only.
- Backpressure: out_ready[1]=0 for 3 cycles while channel 1 holds data 77 -> in_ready=0; out_valid=0010 and data 77 stable. out_ready[0]=1 has no effect. Beat drains on the cycle out_ready[1] rises; the next beat follows with no bubble.
- Drop, NCH=3: 2-beat packet with sel=3 -> in_ready=1 on both beats, out_valid stays 000, err_drop pulses once. The following packet with sel=1 is routed normally. With STREAM_DEMUX_DROP_CNT_EN defined, drop_cnt goes 0->1.
- Channel switch: last beat to channel 0 stalled (out_ready[0]=0), next packet sel=3 -> in_ready=0 until channel 0 drains, then out_valid=1000 one cycle after acceptance.
